matmul_mem_slave: RTL

- Memory target that sits directly downstream of the matmul controller/dot-product engine.
- Serves its request stream: mem_req, mem_write, mem_addr, mem_wdata.
- Returns read data in order on mem_rdata/mem_rdata_vld after a fixed, parameterised latency. No backpressure.
- Provides a backdoor load/peek port for preloading A/B and checking C, plus sticky error flags and access counters.

---
 rtl/matmul_mem_slave.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/matmul_mem_slave.sv
// Single-port word memory behind the matmul engine: in-order fixed-latency reads,
// a backdoor load/peek port, sticky error flags and saturating access counters.
module matmul_mem_slave #(
    parameter int MEM_AW     = 16,
    parameter int MEM_DW     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_write,
    input  logic [MEM_AW-1:0]     mem_addr,
    input  logic [MEM_DW-1:0]     mem_wdata,
    output logic                  mem_rdata_vld,
    output logic [MEM_DW-1:0]     mem_rdata,
    input  logic                  bd_en,
    input  logic [DEPTH_LOG2-1:0] bd_addr,
    input  logic [MEM_DW-1:0]     bd_wdata,
    output logic [MEM_DW-1:0]     bd_rdata,
    input  logic                  clr,
    output logic                  err_oor,
    output logic                  err_bd_col,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      wr_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Any address bit above the implemented range marks the access out of range.
    function automatic logic addr_oor(input logic [MEM_AW-1:0] a);
        return (a >> DEPTH_LOG2) != {MEM_AW{1'b0}};
    endfunction

    // Saturating increment: all-ones is sticky until cleared.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end else begin
            return c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [MEM_DW-1:0]     mem_q [DEPTH];
    logic                  wr_s;
    logic                  rd_s;
    logic                  oor_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic [MEM_DW-1:0]     rd_data_s;

    logic [RD_LAT-1:0]     vld_q;
    logic [MEM_DW-1:0]     dat_q [RD_LAT];

    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic                  err_oor_q, err_oor_d;
    logic                  err_bd_col_q, err_bd_col_d;

    assign wr_s  = mem_req & mem_write;
    assign rd_s  = mem_req & ~mem_write;
    assign oor_s = addr_oor(mem_addr);
    assign idx_s = mem_addr[DEPTH_LOG2-1:0];

    // Read data as of before the current edge; out-of-range reads return zero.
    always_comb begin
        rd_data_s = {MEM_DW{1'b0}};
        if (oor_s) begin
            rd_data_s = {MEM_DW{1'b0}};
        end else begin
            rd_data_s = mem_q[idx_s];
        end
    end

    // Storage array; not reset so preloaded contents survive rst_n. Functional writes beat the backdoor.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            if (!oor_s) begin
                mem_q[idx_s] <= mem_wdata;
            end
        end else if (bd_en) begin
            mem_q[bd_addr] <= bd_wdata;
        end
    end

    assign bd_rdata = mem_q[bd_addr];

    // Read response shift pipeline; each stage's data only moves with a valid so the output holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= {MEM_DW{1'b0}};
            end
        end else begin
            vld_q[0] <= rd_s;
            if (rd_s) begin
                dat_q[0] <= rd_data_s;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign mem_rdata_vld = vld_q[RD_LAT-1];
    assign mem_rdata     = dat_q[RD_LAT-1];

    // Counter and sticky-flag next state; clr overrides any same-cycle update.
    always_comb begin
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        err_oor_d    = err_oor_q;
        err_bd_col_d = err_bd_col_q;
        if (clr) begin
            rd_cnt_d     = {CNT_W{1'b0}};
            wr_cnt_d     = {CNT_W{1'b0}};
            err_oor_d    = 1'b0;
            err_bd_col_d = 1'b0;
        end else begin
            if (rd_s) begin
                rd_cnt_d = sat_inc(rd_cnt_q);
            end else begin
                rd_cnt_d = rd_cnt_q;
            end
            if (wr_s) begin
                wr_cnt_d = sat_inc(wr_cnt_q);
            end else begin
                wr_cnt_d = wr_cnt_q;
            end
            if (mem_req && oor_s) begin
                err_oor_d = 1'b1;
            end else begin
                err_oor_d = err_oor_q;
            end
            if (bd_en && wr_s) begin
                err_bd_col_d = 1'b1;
            end else begin
                err_bd_col_d = err_bd_col_q;
            end
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q     <= {CNT_W{1'b0}};
            wr_cnt_q     <= {CNT_W{1'b0}};
            err_oor_q    <= 1'b0;
            err_bd_col_q <= 1'b0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            err_oor_q    <= err_oor_d;
            err_bd_col_q <= err_bd_col_d;
        end
    end

    assign rd_cnt     = rd_cnt_q;
    assign wr_cnt     = wr_cnt_q;
    assign err_oor    = err_oor_q;
    assign err_bd_col = err_bd_col_q;

endmodule
